// File: rtl/rq_pkg.sv
// Shared encodings for the elevator request scheduler: direction codes driven
// on ud_mode and the scheduler state values.
package rq_pkg;

   localparam logic [1:0] MODE_STOP = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;
   localparam logic [1:0] ST_DOOR = 2'd3;

   function automatic logic [1:0] state_mode(input logic [1:0] st);
      case (st)
         ST_UP:   return MODE_UP;
         ST_DOWN: return MODE_DOWN;
         default: return MODE_STOP;
      endcase
   endfunction

endpackage

// File: rtl/rq_mask.sv
// Combinational floor masks: is anything pending above, below or at the
// car's one-hot position.
module rq_mask
   import rq_pkg::*;
#(
   parameter int FLOORS = 4
) (
   input  logic [FLOORS-1:0] position,
   input  logic [FLOORS-1:0] pend,
   output logic              above_any,
   output logic              below_any,
   output logic              here_any
);

   logic [FLOORS-1:0] above_mask;
   logic [FLOORS-1:0] below_mask;
   logic              seen;

   // A floor is "above" once the position bit has been passed scanning upwards.
   always_comb begin
      above_mask = '0;
      below_mask = '0;
      seen       = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         above_mask[i] = seen;
         seen          = seen | position[i];
      end
      seen = 1'b0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         below_mask[i] = seen;
         seen          = seen | position[i];
      end
   end

   assign above_any = |(pend & above_mask);
   assign below_any = |(pend & below_mask);
   assign here_any  = |(pend & position);

endmodule

// File: rtl/rq_scheduler.sv
// Elevator request scheduler: latches hall/car calls, chooses travel direction
// and commands stops, collective in the direction of travel.
module rq_scheduler
   import rq_pkg::*;
#(
   parameter int FLOORS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLOORS-1:0] up_req,
   input  logic [FLOORS-1:0] down_req,
   input  logic [FLOORS-1:0] in_ele_req,
   input  logic [FLOORS-1:0] position,
   input  logic              arrive,
   input  logic              door_done,
   output logic [1:0]        ud_mode,
   output logic              stop,
   output logic [FLOORS-1:0] up_lamp,
   output logic [FLOORS-1:0] down_lamp,
   output logic [FLOORS-1:0] in_lamp,
   output logic              pos_err
);

   localparam logic [FLOORS-1:0] ONE   = {{(FLOORS-1){1'b0}}, 1'b1};
   localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

   logic [1:0]        state_q, state_d;
   logic              dir_up_q, dir_up_d;
   logic              stop_q, stop_d;
   logic [FLOORS-1:0] up_q, up_d, dn_q, dn_d, in_q, in_d;
   logic              pos_ok, above_any, below_any, here_any;
   logic              up_here, dn_here, in_here;
   logic              serve, serve_up, door_clr, clr_up, clr_dn, clr_in;

   assign pos_ok  = (position != '0) && ((position & (position - ONE)) == '0);
   assign pos_err = ~pos_ok;
   assign up_here = |(up_q & position);
   assign dn_here = |(dn_q & position);
   assign in_here = |(in_q & position);

   rq_mask #(.FLOORS(FLOORS)) u_mask (
      .position  (position),
      .pend      (up_q | dn_q | in_q),
      .above_any (above_any),
      .below_any (below_any),
      .here_any  (here_any)
   );

   // All transitions are frozen while position is not a single floor.
   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      stop_d   = 1'b0;
      serve    = 1'b0;
      serve_up = dir_up_q;
      if (pos_ok) begin
         case (state_q)
            ST_IDLE: begin
               if (here_any) begin
                  serve    = 1'b1;
                  serve_up = up_here | ~dn_here;
               end else if (above_any) begin
                  state_d = ST_UP;
               end else if (below_any) begin
                  state_d = ST_DOWN;
               end
            end
            ST_UP: begin
               if (arrive && (up_here || in_here)) begin
                  serve    = 1'b1;
                  serve_up = 1'b1;
               end else if (arrive && dn_here && !above_any) begin
                  serve    = 1'b1;
                  serve_up = 1'b0;
               end else if (!above_any && !here_any) begin
                  state_d = ST_IDLE;
               end
            end
            ST_DOWN: begin
               if (arrive && (dn_here || in_here)) begin
                  serve    = 1'b1;
                  serve_up = 1'b0;
               end else if (arrive && up_here && !below_any) begin
                  serve    = 1'b1;
                  serve_up = 1'b1;
               end else if (!below_any && !here_any) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               if (door_done) begin
                  if (dir_up_q) begin
                     if (above_any)                state_d = ST_UP;
                     else if (below_any || dn_here) state_d = ST_DOWN;
                     else                          state_d = ST_IDLE;
                  end else begin
                     if (below_any)                state_d = ST_DOWN;
                     else if (above_any || up_here) state_d = ST_UP;
                     else                          state_d = ST_IDLE;
                  end
               end
            end
         endcase
      end
      if (serve) begin
         state_d  = ST_DOOR;
         stop_d   = 1'b1;
         dir_up_d = serve_up;
      end
   end

   // Clears win over a press of the same bit in the same cycle.
   always_comb begin
      door_clr = pos_ok && (state_q == ST_DOOR);
      clr_in   = serve | door_clr;
      clr_up   = (serve & serve_up) | (door_clr & dir_up_q);
      clr_dn   = (serve & ~serve_up) | (door_clr & ~dir_up_q);
      up_d     = (up_q | (up_req & UP_OK)) & ~(position & {FLOORS{clr_up}});
      dn_d     = (dn_q | (down_req & DN_OK)) & ~(position & {FLOORS{clr_dn}});
      in_d     = (in_q | in_ele_req) & ~(position & {FLOORS{clr_in}});
   end

   // NOTE: reset clears every pending call, so a reset mid-trip forgets all requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         dir_up_q <= 1'b1;
         stop_q   <= 1'b0;
         up_q     <= '0;
         dn_q     <= '0;
         in_q     <= '0;
      end else begin
         state_q  <= state_d;
         dir_up_q <= dir_up_d;
         stop_q   <= stop_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         in_q     <= in_d;
      end
   end

   assign ud_mode   = state_mode(state_q);
   assign stop      = stop_q;
   assign up_lamp   = up_q;
   assign down_lamp = dn_q;
   assign in_lamp   = in_q;

endmodule

// File: tb/tb_rq_scheduler.sv
// Scoreboard bench for rq_scheduler: a floor-level reference model predicts
// every post-edge output snapshot; a monitor pops and compares each cycle.
module tb_rq_scheduler;

   logic       clk, rst_n, rst8_n;
   logic [3:0] up_req, down_req, in_ele_req, position;
   logic       arrive, door_done;
   logic [1:0] ud_mode;
   logic       stop, pos_err;
   logic [3:0] up_lamp, down_lamp, in_lamp;

   logic [7:0] up8, dn8, in8, pos8, upl8, dnl8, inl8;
   logic       arr8, dd8, stop8, perr8;
   logic [1:0] ud8;

   int checks = 0;
   int errors = 0;

   rq_scheduler #(.FLOORS(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .up_req(up_req), .down_req(down_req),
      .in_ele_req(in_ele_req), .position(position), .arrive(arrive),
      .door_done(door_done), .ud_mode(ud_mode), .stop(stop),
      .up_lamp(up_lamp), .down_lamp(down_lamp), .in_lamp(in_lamp),
      .pos_err(pos_err)
   );

   rq_scheduler #(.FLOORS(8)) u_dut8 (
      .clk(clk), .rst_n(rst8_n), .up_req(up8), .down_req(dn8),
      .in_ele_req(in8), .position(pos8), .arrive(arr8),
      .door_done(dd8), .ud_mode(ud8), .stop(stop8),
      .up_lamp(upl8), .down_lamp(dnl8), .in_lamp(inl8),
      .pos_err(perr8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (floor-indexed call lists) ----------------
   typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mstate_t;
   mstate_t     m_st;
   bit          m_dir_up, m_stop;
   bit          m_up[4], m_dn[4], m_in[4];
   logic [15:0] exp_q[$];

   task automatic model_reset();
      m_st = M_IDLE;
      m_dir_up = 1'b1;
      m_stop = 1'b0;
      for (int f = 0; f < 4; f++) begin
         m_up[f] = 0; m_dn[f] = 0; m_in[f] = 0;
      end
   endtask

   task automatic model_step(input logic [3:0] ur, dr, ir, pos, input logic ar, dd);
      int fl, n;
      bit ok, ab, be, uh, dh, ih, serve, sup, clearing, sd;
      mstate_t nx;
      logic [1:0] mode;
      logic [3:0] uv, dv, iv;
      n = 0; fl = 0;
      for (int f = 0; f < 4; f++) if (pos[f]) begin n++; fl = f; end
      ok = (n == 1);
      ab = 0; be = 0;
      for (int f = 0; f < 4; f++) begin
         if (f > fl && (m_up[f] || m_dn[f] || m_in[f])) ab = 1;
         if (f < fl && (m_up[f] || m_dn[f] || m_in[f])) be = 1;
      end
      uh = m_up[fl]; dh = m_dn[fl]; ih = m_in[fl];
      nx = m_st; serve = 0; sup = m_dir_up;
      if (ok) begin
         if (m_st == M_IDLE) begin
            if (uh || dh || ih) begin serve = 1; sup = uh || !dh; end
            else if (ab) nx = M_UP;
            else if (be) nx = M_DOWN;
         end else if (m_st == M_UP) begin
            if (ar && (uh || ih)) begin serve = 1; sup = 1; end
            else if (ar && dh && !ab) begin serve = 1; sup = 0; end
            else if (!ab && !(uh || dh || ih)) nx = M_IDLE;
         end else if (m_st == M_DOWN) begin
            if (ar && (dh || ih)) begin serve = 1; sup = 0; end
            else if (ar && uh && !be) begin serve = 1; sup = 1; end
            else if (!be && !(uh || dh || ih)) nx = M_IDLE;
         end else if (dd) begin
            if (m_dir_up) nx = ab ? M_UP : ((be || dh) ? M_DOWN : M_IDLE);
            else          nx = be ? M_DOWN : ((ab || uh) ? M_UP : M_IDLE);
         end
      end
      clearing = serve || (ok && m_st == M_DOOR);
      sd = serve ? sup : m_dir_up;
      for (int f = 0; f < 4; f++) begin
         m_up[f] = (m_up[f] || (ur[f] && f != 3)) && !(clearing && sd && f == fl);
         m_dn[f] = (m_dn[f] || (dr[f] && f != 0)) && !(clearing && !sd && f == fl);
         m_in[f] = (m_in[f] || ir[f]) && !(clearing && f == fl);
      end
      if (serve) begin m_st = M_DOOR; m_dir_up = sup; m_stop = 1; end
      else begin m_st = nx; m_stop = 0; end
      mode = (m_st == M_UP) ? 2'b01 : (m_st == M_DOWN) ? 2'b10 : 2'b00;
      for (int f = 0; f < 4; f++) begin uv[f] = m_up[f]; dv[f] = m_dn[f]; iv[f] = m_in[f]; end
      exp_q.push_back({mode, m_stop, uv, dv, iv, !ok});
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("snapshot{mode,stop,up,dn,in,perr}",
                  {16'h0, ud_mode, stop, up_lamp, down_lamp, in_lamp, pos_err}, {16'h0, e});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [3:0] ur, dr, ir, pos, input logic ar, dd);
      @(negedge clk);
      up_req = ur; down_req = dr; in_ele_req = ir; position = pos;
      arrive = ar; door_done = dd;
      model_step(ur, dr, ir, pos, ar, dd);
   endtask

   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   int stops8, stop_floor8, cf;

   task automatic cyc8(input logic [7:0] ir, input int fl, input logic ar);
      @(negedge clk);
      in8 = ir; pos8 = 8'(1 << fl); arr8 = ar;
      @(posedge clk);
      #1;
      if (stop8) begin stops8++; stop_floor8 = fl; end
   endtask

   initial begin
      logic [3:0] ur, dr, ir, pos;
      logic       ar, dd;
      rst_n = 1'b0; rst8_n = 1'b0;
      up_req = '0; down_req = '0; in_ele_req = '0; position = 4'b0011;
      arrive = 1'b0; door_done = 1'b0;
      up8 = '0; dn8 = '0; in8 = '0; pos8 = 8'h01; arr8 = 1'b0; dd8 = 1'b0;
      model_reset();
      #13;
      check("reset_mode", ud_mode, 2'b00);
      check("reset_stop", stop, 1'b0);
      check("reset_lamps", {up_lamp, down_lamp, in_lamp}, 12'h000);
      check("reset_pos_err_comb", pos_err, 1'b1);
      position = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;

      // car call to top floor from ground
      cyc(0, 0, 4'b1000, 4'b0001, 0, 0);
      peek(); check("call_latched", in_lamp, 4'b1000);
      check("idle_one_cycle", ud_mode, 2'b00);
      cyc(0, 0, 0, 4'b0001, 0, 0);
      peek(); check("up_second_cycle", ud_mode, 2'b01);
      cyc(0, 0, 0, 4'b0010, 1, 0);
      cyc(0, 0, 0, 4'b0100, 1, 0);
      peek(); check("no_stop_passing", stop, 1'b0);
      cyc(0, 0, 0, 4'b1000, 1, 0);
      peek(); check("stop_at_top", {stop, in_lamp}, 5'b10000);
      cyc(0, 0, 0, 4'b1000, 0, 0);
      peek(); check("stop_one_cycle", stop, 1'b0);
      cyc(0, 0, 0, 4'b1000, 0, 1);
      peek(); check("idle_after_door", ud_mode, 2'b00);

      // go down to floor 1
      cyc(0, 0, 4'b0010, 4'b1000, 0, 0);
      cyc(0, 0, 0, 4'b1000, 0, 0);
      cyc(0, 0, 0, 4'b0100, 1, 0);
      cyc(0, 0, 0, 4'b0010, 1, 0);
      cyc(0, 0, 0, 4'b0010, 0, 1);

      // up and down calls at floor 2, car rising from floor 1
      cyc(4'b0100, 4'b0100, 0, 4'b0010, 0, 0);
      cyc(0, 0, 0, 4'b0010, 0, 0);
      peek(); check("moving_up", ud_mode, 2'b01);
      cyc(0, 0, 0, 4'b0100, 1, 0);
      peek(); check("serve_up_only", {stop, up_lamp, down_lamp}, 9'b1_0000_0100);
      cyc(4'b0100, 0, 4'b0100, 4'b0100, 0, 0);
      peek(); check("press_in_door_cleared", {up_lamp, in_lamp}, 8'h00);
      cyc(0, 0, 0, 4'b0100, 0, 1);
      peek(); check("reverse_down", {ud_mode, down_lamp}, 6'b10_0100);
      cyc(0, 0, 0, 4'b0100, 1, 0);
      cyc(0, 0, 0, 4'b0100, 0, 1);

      // reversal stop while descending
      cyc(4'b0010, 0, 0, 4'b0100, 0, 0);
      cyc(0, 0, 0, 4'b0100, 0, 0);
      peek(); check("moving_down", ud_mode, 2'b10);
      cyc(0, 0, 0, 4'b0010, 1, 0);
      peek(); check("reversal_stop", {stop, up_lamp}, 5'b10000);
      cyc(0, 0, 0, 4'b0010, 0, 1);
      peek(); check("reversal_idle", ud_mode, 2'b00);

      // bad position while moving up
      cyc(0, 0, 4'b1000, 4'b0010, 0, 0);
      cyc(0, 0, 0, 4'b0010, 0, 0);
      cyc(0, 0, 4'b0100, 4'b0110, 1, 0);
      peek(); check("pos_err_hold", {pos_err, ud_mode, stop, in_lamp}, 8'b1_01_0_1100);
      cyc(0, 0, 0, 4'b0100, 1, 0);
      cyc(0, 0, 0, 4'b0100, 0, 1);
      cyc(0, 0, 0, 4'b1000, 1, 0);
      cyc(0, 0, 0, 4'b1000, 0, 1);

      // async reset while the door is open with calls pending
      cyc(0, 0, 4'b1001, 4'b1000, 0, 0);
      cyc(0, 0, 0, 4'b1000, 0, 0);
      cyc(0, 0, 0, 4'b1000, 0, 0);
      peek(); check("door_lamps_pending", in_lamp, 4'b0001);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_mode", ud_mode, 2'b00);
      check("midreset_lamps", {stop, up_lamp, down_lamp, in_lamp}, 13'h0);
      rst_n = 1'b1;
      model_reset();
      cyc(4'b0001, 0, 0, 4'b1000, 0, 0);
      peek(); check("post_reset_accept", {stop, up_lamp}, 5'b00001);

      // randomized traffic
      cf = 3;
      for (int i = 0; i < 3000; i++) begin
         ur = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         dr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         ir = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         ar = 1'b0; dd = 1'b0;
         if (m_st == M_UP && $urandom_range(0, 2) == 0) begin
            if (cf < 3) cf++;
            ar = 1'b1;
         end else if (m_st == M_DOWN && $urandom_range(0, 2) == 0) begin
            if (cf > 0) cf--;
            ar = 1'b1;
         end else if (m_st == M_DOOR && $urandom_range(0, 3) == 0) begin
            dd = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) ar = 1'b1;
         if ($urandom_range(0, 19) == 0) dd = 1'b1;
         pos = 4'(1 << cf);
         if ($urandom_range(0, 49) == 0) pos = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1011;
         cyc(ur, dr, ir, pos, ar, dd);
      end
      cyc(0, 0, 0, 4'(1 << cf), 0, 0);

      // eight floors: one car call to the top, arrive at every floor
      stops8 = 0; stop_floor8 = -1;
      @(negedge clk);
      rst8_n = 1'b1;
      cyc8(8'h80, 0, 0);
      cyc8(8'h00, 0, 0);
      check("f8_moving_up", ud8, 2'b01);
      for (int f = 1; f < 8; f++) begin
         cyc8(8'h00, f, 1);
         cyc8(8'h00, f, 0);
      end
      check("f8_stop_count", stops8, 1);
      check("f8_stop_floor", stop_floor8, 7);
      check("f8_lamp_cleared", inl8, 8'h00);

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rq_scheduler.md
RQ_SCHEDULER -- requirements
Module: rq_scheduler

Interface
REQ-001 The block SHALL have parameter FLOORS, default 4, giving the number of floors (legal 2..16; bit i = floor i, bit 0 = ground).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port up_req, input, FLOORS, hall up-button pulses; bit FLOORS-1 is ignored.
REQ-005 The block SHALL have port down_req, input, FLOORS, hall down-button pulses; bit 0 is ignored.
REQ-006 The block SHALL have port in_ele_req, input, FLOORS, car-panel button pulses.
REQ-007 The block SHALL have port position, input, FLOORS, one-hot current car floor.
REQ-008 The block SHALL have port arrive, input, 1, one-cycle pulse when the car is level with position.
REQ-009 The block SHALL have port door_done, input, 1, one-cycle pulse when the door cycle has finished.
REQ-010 The block SHALL have port ud_mode, output, 2, direction: 00 stop, 01 up, 10 down.
REQ-011 The block SHALL have port stop, output, 1, one-cycle pulse commanding a stop and door open at position.
REQ-012 The block SHALL have ports up_lamp, down_lamp and in_lamp, output, FLOORS each, carrying the latched pending requests.
REQ-013 The block SHALL have port pos_err, output, 1, which is high while position is not one-hot.

Function
REQ-014 The block SHALL OR each request input into its pending register every cycle; the new value is visible on the lamps one cycle later.
REQ-015 The block SHALL implement states IDLE, UP, DOWN and DOOR.
- ud_mode = 01 in UP, 10 in DOWN, 00 in IDLE and DOOR.
REQ-016 In IDLE, the block SHALL select its next state from pending requests at or relative to position, in this priority order:
- any pending request at position: enter DOOR and pulse stop;
- otherwise any request above: enter UP;
- otherwise any request below: enter DOWN;
- otherwise remain in IDLE.
REQ-017 In UP, on arrive, the block SHALL stop at position if either condition holds, and otherwise keep moving:
- up_lamp or in_lamp is set at position;
- down_lamp is set at position and no request of any type exists above.
REQ-018 In DOWN, on arrive, the block SHALL stop at position if either condition holds, and otherwise keep moving:
- down_lamp or in_lamp is set at position;
- up_lamp is set at position and no request of any type exists below.
REQ-019 On a stop, the block SHALL pulse stop for exactly one cycle, enter DOOR, and in the same edge clear in_lamp plus the hall bit for the served direction at position.
- The served direction is UP or DOWN as moving; for a reversal stop it is the reversed direction.
REQ-020 In DOOR, on door_done, the block SHALL do the following:
- continue in the prior direction if requests remain in that direction;
- otherwise reverse if requests exist opposite;
- otherwise go to IDLE.
REQ-021 A request pressed at position while the block is in DOOR SHALL be cleared immediately if it is in_ele_req or matches the served direction; any other request at position SHALL stay latched.
REQ-022 In UP with no requests above and none at position, the block SHALL return to IDLE on the next cycle and SHALL never run past the top floor.
- The symmetric rule SHALL apply in DOWN at the lowest floor.
REQ-023 arrive SHALL be ignored in IDLE and DOOR, and door_done SHALL be ignored outside DOOR.
REQ-024 While position is not one-hot, the block SHALL hold its state, suppress stop, continue latching requests, and assert pos_err.
REQ-025 A simultaneous press and clear of the same bit SHALL resolve to clear, and the press is lost.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously set state to IDLE, clear all lamp registers, and drive ud_mode = 00 and stop = 0.
- pos_err remains combinational from position.
REQ-027 A reset asserted mid-motion or mid-door SHALL discard all pending requests.
- After release, the block SHALL accept new requests from the first clock edge.

Structure
REQ-028 Package rq_pkg SHALL hold the ud_mode encodings (MODE_STOP, MODE_UP, MODE_DOWN) and the state enumeration.
REQ-029 A combinational sub-module rq_mask SHALL derive the above_any, below_any and here_any flags from position and the pending vectors; it is instantiated once.

Verification
REQ-030 With FLOORS=4 and the car at 0001 in IDLE, pulsing in_ele_req=1000 SHALL give ud_mode=01 on the second cycle, and arrive at 1000 SHALL give one stop pulse with in_lamp=0000.
REQ-031 With the car moving UP at 0010 and pending up_lamp=0100 and down_lamp=0100, arrive at 0100 SHALL stop and clear only up_lamp bit 2; after door_done, ud_mode SHALL become 10 and down_lamp=0100 SHALL remain.
REQ-032 With the car moving DOWN at 0100 and up_lamp=0010 only, arrive at 0010 SHALL stop as a reversal, clear up_lamp, and give IDLE after door_done.
REQ-033 Pulsing rst_n low for 1 ns during DOOR with lamps non-zero SHALL immediately give ud_mode=00 and all lamps zero, with no stop pulse after release.
REQ-034 Driving position=0110 while in UP SHALL assert pos_err, hold the state and suppress stop on arrive.
REQ-035 With FLOORS=8, in_ele_req=10000000 from floor 0 with arrive pulses at floors 1..7 SHALL give exactly one stop pulse, at floor 7.
